grf_writeback: RTL and testbench
================================

# grf_writeback

Writeback stage and general register file of the five-stage MIPS pipeline. Consumes the W-stage register outputs, selects the writeback value (ALU result, memory load data, or link address), and commits it to a 32×32 register file. Serves the two D-stage read ports with write-through bypass and keeps a retired-instruction counter for debug.

## Interface
Parameters:
- `RESET_PC_BASE`, default 32'h0000_3000: base address used only to flag `W_Instr`/`W_PC` bubbles; a cycle is a bubble when `W_Instr == 0`.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `W_Instr`  in  32  instruction in W stage (0 = bubble).
- `W_PC`  in  32  PC of the W instruction.
- `W_A3`  in  5  destination register number.
- `W_ALU_result`  in  32  ALU result carried from E/M.
- `W_data`  in  32  load data from data memory.
- `W_jump`  in  1  instruction is a linking jump/branch.
- `W_judge`  in  1  branch condition result for conditional-link instructions.
- `D_rs_addr`  in  5  read port 1 address.
- `D_rt_addr`  in  5  read port 2 address.
- `D_rs_data`  out  32  read port 1 data (combinational).
- `D_rt_data`  out  32  read port 2 data (combinational).
- `W_we`  out  1  effective write enable this cycle (combinational).
- `W_wdata`  out  32  selected writeback value (combinational).
- `retired`  out  32  count of non-bubble instructions committed.

## Operation
- Decode: `op = W_Instr[31:26]`.
- Writeback select, priority order:
  - `W_jump == 1` → `W_PC + 8` (32-bit, wraps modulo 2^32).
  - `op` ∈ {100011 lw, 100001 lh, 100101 lhu, 100000 lb, 100100 lbu} → `W_data`.
  - otherwise → `W_ALU_result`.
- Write enable `W_we` = `W_A3 != 0` AND NOT (`W_jump == 1` AND `op == 000001` AND `W_judge == 0`), i.e. REGIMM conditional-links write only when taken.
- On a rising edge with `W_we == 1`: `GRF[W_A3] <= W_wdata`. Register 0 is never written and always reads 0.
- Read ports: address 0 → 0; else if `W_we` AND address == `W_A3` → `W_wdata` (write-through bypass); else `GRF[address]`. Both ports bypass independently; same address on both ports returns the same value.
- `retired` increments by 1 on each rising edge where `W_Instr != 0`, regardless of `W_we`; wraps from 32'hFFFF_FFFF to 0.
- `W_V2` is not consumed by this block.

## Timing
- Write latency: value visible in the array one edge after W; visible on read ports in the same cycle via bypass, so D-stage reads never see stale data for the W-stage destination.
- Reads and `W_we`/`W_wdata` are purely combinational from current inputs and array state.
- Reset (edge with `reset == 1`): all 32 registers ← 0, `retired` ← 0; any write presented in the same cycle is discarded. Outputs after reset: `D_rs_data`/`D_rt_data` = 0 for all non-bypassed addresses, `retired` = 0. `W_we`/`W_wdata` follow inputs combinationally (a reset W register drives `W_A3 = 0`, so `W_we = 0`).
- Reset mid-stream: takes effect at that edge; writes resume on the first edge with `reset == 0`.
- Bubble (`W_Instr == 0`, `W_A3 == 0`): no write, no count.

## Test plan
- Reset, then read all 32 addresses → all 0, `retired == 0`.
- `W_Instr=32'h0109_5021` (addu $10), `W_A3=10`, `W_ALU_result=32'h1234_5678`, `D_rs_addr=10` → `D_rs_data` = 32'h1234_5678 same cycle (bypass), array holds it next cycle, `retired` = 1.
- lw (`op=100011`), `W_A3=5`, `W_data=32'hDEAD_BEEF`, `W_ALU_result=32'h0000_0010` → register 5 = 32'hDEAD_BEEF.
- jal: `W_jump=1`, `W_PC=32'h0000_3004`, `W_A3=31` → register 31 = 32'h0000_300C; bgezal (`op=000001`) with `W_judge=0` → `W_we=0`, register 31 unchanged; with `W_judge=1` → written.
- Write to `W_A3=0` with data 32'hFFFF_FFFF → `W_we=0`, reading address 0 on both ports returns 0.
- Write register 7 then assert `reset` together with a second write to 7 → register 7 = 0, `retired` = 0 after the edge.

Source files
------------

// File: rtl/grf_writeback.sv
// Writeback stage plus 32x32 general register file.
// Selects the W-stage result, commits it to the array, serves two
// D-stage read ports with write-through bypass, and counts retired
// (non-bubble) instructions.
module grf_writeback #(
  parameter logic [31:0] RESET_PC_BASE = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] W_Instr,
  input  logic [31:0] W_PC,
  input  logic [4:0]  W_A3,
  input  logic [31:0] W_ALU_result,
  input  logic [31:0] W_data,
  input  logic        W_jump,
  input  logic        W_judge,
  input  logic [4:0]  D_rs_addr,
  input  logic [4:0]  D_rt_addr,
  output logic [31:0] D_rs_data,
  output logic [31:0] D_rt_data,
  output logic        W_we,
  output logic [31:0] W_wdata,
  output logic [31:0] retired
);

  localparam logic [5:0] OpRegimm = 6'b000001;
  localparam logic [5:0] OpLw     = 6'b100011;
  localparam logic [5:0] OpLh     = 6'b100001;
  localparam logic [5:0] OpLhu    = 6'b100101;
  localparam logic [5:0] OpLb     = 6'b100000;
  localparam logic [5:0] OpLbu    = 6'b100100;

  // Bubbles are identified by a zero instruction word alone; the base
  // PC is kept on the interface for compatibility with the W register.
  logic unused_pc_base;
  assign unused_pc_base = ^RESET_PC_BASE;

  logic [31:0] grf_q [32];
  logic [31:0] grf_d [32];
  logic [31:0] retired_q, retired_d;

  logic [5:0] op;
  logic       is_load;
  logic       is_bubble;
  logic       link_not_taken;

  // Decode and writeback value/enable selection.
  always_comb begin
    op             = W_Instr[31:26];
    is_bubble      = (W_Instr == 32'h0000_0000);
    is_load        = (op == OpLw) || (op == OpLh) || (op == OpLhu) ||
                     (op == OpLb) || (op == OpLbu);
    // REGIMM conditional links only write the link register when taken.
    link_not_taken = W_jump && (op == OpRegimm) && !W_judge;
    W_we           = (W_A3 != 5'd0) && !link_not_taken;
    if (W_jump) begin
      W_wdata = W_PC + 32'd8;
    end else if (is_load) begin
      W_wdata = W_data;
    end else begin
      W_wdata = W_ALU_result;
    end
  end

  // Next-state for the array and the retired counter.
  always_comb begin
    grf_d = grf_q;
    if (W_we) begin
      grf_d[W_A3] = W_wdata;
    end
    retired_d = is_bubble ? retired_q : retired_q + 32'd1;
  end

  // State registers; reset discards any write presented in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        grf_q[i] <= 32'h0000_0000;
      end
      retired_q <= 32'h0000_0000;
    end else begin
      for (int i = 0; i < 32; i++) begin
        grf_q[i] <= grf_d[i];
      end
      retired_q <= retired_d;
    end
  end

  // Read ports with write-through bypass of the W-stage destination.
  always_comb begin
    if (D_rs_addr == 5'd0) begin
      D_rs_data = 32'h0000_0000;
    end else if (W_we && (D_rs_addr == W_A3)) begin
      D_rs_data = W_wdata;
    end else begin
      D_rs_data = grf_q[D_rs_addr];
    end

    if (D_rt_addr == 5'd0) begin
      D_rt_data = 32'h0000_0000;
    end else if (W_we && (D_rt_addr == W_A3)) begin
      D_rt_data = W_wdata;
    end else begin
      D_rt_data = grf_q[D_rt_addr];
    end
  end

  assign retired = retired_q;

endmodule

// File: tb/tb_grf_writeback.sv
// Scoreboard bench for grf_writeback: each driven cycle pushes its
// hand-computed expected outputs; a negedge monitor pops and compares.
module tb_grf_writeback;

  logic        clk;
  logic        reset;
  logic [31:0] W_Instr, W_PC, W_ALU_result, W_data;
  logic [4:0]  W_A3, D_rs_addr, D_rt_addr;
  logic        W_jump, W_judge;
  logic [31:0] D_rs_data, D_rt_data, W_wdata, retired;
  logic        W_we;

  grf_writeback #(.RESET_PC_BASE(32'h0000_3000)) dut (
    .clk          (clk),
    .reset        (reset),
    .W_Instr      (W_Instr),
    .W_PC         (W_PC),
    .W_A3         (W_A3),
    .W_ALU_result (W_ALU_result),
    .W_data       (W_data),
    .W_jump       (W_jump),
    .W_judge      (W_judge),
    .D_rs_addr    (D_rs_addr),
    .D_rt_addr    (D_rt_addr),
    .D_rs_data    (D_rs_data),
    .D_rt_data    (D_rt_data),
    .W_we         (W_we),
    .W_wdata      (W_wdata),
    .retired      (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] ret;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic cmp(input string nm, input string field,
                     input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h, expected %h", nm, field, act, exp);
    end
  endtask

  // Monitor: one expectation per driven cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      cmp(e.nm, "rs_data", D_rs_data, e.rs);
      cmp(e.nm, "rt_data", D_rt_data, e.rt);
      cmp(e.nm, "we",      {31'd0, W_we}, {31'd0, e.we});
      cmp(e.nm, "wdata",   W_wdata, e.wdata);
      cmp(e.nm, "retired", retired, e.ret);
    end
  end

  // Drive one cycle of inputs just after the edge and queue the expectation.
  task automatic drive(input string nm, input logic rst, input logic [31:0] instr,
                       input logic [31:0] pc, input logic [4:0] a3,
                       input logic [31:0] alu, input logic [31:0] data,
                       input logic jump, input logic judge,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic [31:0] e_rs, input logic [31:0] e_rt,
                       input logic e_we, input logic [31:0] e_wdata,
                       input logic [31:0] e_ret);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; W_Instr = instr; W_PC = pc; W_A3 = a3;
    W_ALU_result = alu; W_data = data; W_jump = jump; W_judge = judge;
    D_rs_addr = rs; D_rt_addr = rt;
    e.nm = nm; e.rs = e_rs; e.rt = e_rt; e.we = e_we; e.wdata = e_wdata; e.ret = e_ret;
    sb.push_back(e);
  endtask

  initial begin
    int w;
    reset = 1'b1; W_Instr = '0; W_PC = 32'h3000; W_A3 = '0; W_ALU_result = '0;
    W_data = '0; W_jump = 1'b0; W_judge = 1'b0; D_rs_addr = '0; D_rt_addr = '0;
    repeat (2) @(posedge clk);

    // All 32 addresses read zero after reset.
    for (int i = 0; i < 16; i++) begin
      drive("rd_after_reset", 1'b0, 32'h0, 32'h3000, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0,
            5'(i), 5'(i + 16), 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    end

    // addu $10 with same-cycle bypass, then array read.
    drive("addu_bypass", 1'b0, 32'h0109_5021, 32'h3000, 5'd10, 32'h1234_5678, 32'h0,
          1'b0, 1'b0, 5'd10, 5'd0, 32'h1234_5678, 32'h0, 1'b1, 32'h1234_5678, 32'd0);
    drive("addu_array", 1'b0, 32'h0, 32'h3000, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0,
          5'd10, 5'd10, 32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0, 32'd1);
    // Loads select memory data.
    drive("lw", 1'b0, 32'h8C05_0010, 32'h3004, 5'd5, 32'h0000_0010, 32'hDEAD_BEEF,
          1'b0, 1'b0, 5'd5, 5'd10, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 32'hDEAD_BEEF, 32'd1);
    drive("lbu", 1'b0, 32'h9006_0000, 32'h3008, 5'd6, 32'hFFFF_0000, 32'h0000_00AB,
          1'b0, 1'b0, 5'd6, 5'd5, 32'h0000_00AB, 32'hDEAD_BEEF, 1'b1, 32'h0000_00AB, 32'd2);
    // jal links PC+8 over both ALU and load data.
    drive("jal", 1'b0, 32'h0C00_0C01, 32'h0000_3004, 5'd31, 32'h0000_5555, 32'h0000_6666,
          1'b1, 1'b0, 5'd31, 5'd6, 32'h0000_300C, 32'h0000_00AB, 1'b1, 32'h0000_300C, 32'd3);
    // bgezal not taken: no write, no bypass.
    drive("bgezal_nt", 1'b0, 32'h0411_0004, 32'h0000_3100, 5'd31, 32'h0, 32'h0,
          1'b1, 1'b0, 5'd31, 5'd31, 32'h0000_300C, 32'h0000_300C, 1'b0, 32'h0000_3108, 32'd4);
    drive("bgezal_t", 1'b0, 32'h0411_0004, 32'h0000_3200, 5'd31, 32'h0, 32'h0,
          1'b1, 1'b1, 5'd31, 5'd31, 32'h0000_3208, 32'h0000_3208, 1'b1, 32'h0000_3208, 32'd5);
    drive("r31_array", 1'b0, 32'h0, 32'h3000, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0,
          5'd31, 5'd10, 32'h0000_3208, 32'h1234_5678, 1'b0, 32'h0, 32'd6);
    // Write to $0 is suppressed; $0 reads zero on both ports.
    drive("wr_r0", 1'b0, 32'h0000_0021, 32'h3010, 5'd0, 32'hFFFF_FFFF, 32'h0,
          1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 32'hFFFF_FFFF, 32'd6);
    drive("r0_after", 1'b0, 32'h0, 32'h3000, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0,
          5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0, 32'd7);
    // Link address wraps modulo 2^32.
    drive("jal_wrap", 1'b0, 32'h0C00_0000, 32'hFFFF_FFFC, 5'd3, 32'h0, 32'h0,
          1'b1, 1'b0, 5'd3, 5'd0, 32'h0000_0004, 32'h0, 1'b1, 32'h0000_0004, 32'd7);
    drive("r3_array", 1'b0, 32'h0, 32'h3000, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0,
          5'd3, 5'd0, 32'h0000_0004, 32'h0, 1'b0, 32'h0, 32'd8);
    // Write $7, then reset alongside a second write to $7.
    drive("wr_r7", 1'b0, 32'h00E0_3821, 32'h3014, 5'd7, 32'h7777_7777, 32'h0,
          1'b0, 1'b0, 5'd7, 5'd3, 32'h7777_7777, 32'h0000_0004, 1'b1, 32'h7777_7777, 32'd8);
    drive("r7_array", 1'b0, 32'h0, 32'h3000, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0,
          5'd7, 5'd0, 32'h7777_7777, 32'h0, 1'b0, 32'h0, 32'd9);
    drive("rst_wr_r7", 1'b1, 32'h00E0_3821, 32'h3018, 5'd7, 32'hAAAA_AAAA, 32'h0,
          1'b0, 1'b0, 5'd7, 5'd0, 32'hAAAA_AAAA, 32'h0, 1'b1, 32'hAAAA_AAAA, 32'd9);
    drive("post_rst_a", 1'b0, 32'h0, 32'h3000, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0,
          5'd7, 5'd31, 32'h0, 32'h0, 1'b0, 32'h0, 32'd0);
    drive("post_rst_b", 1'b0, 32'h0, 32'h3000, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0,
          5'd10, 5'd5, 32'h0, 32'h0, 1'b0, 32'h0, 32'd0);
    // Writes resume after reset.
    drive("wr_r2", 1'b0, 32'h0000_1021, 32'h3000, 5'd2, 32'h0000_0042, 32'h0,
          1'b0, 1'b0, 5'd3, 5'd2, 32'h0, 32'h0000_0042, 1'b1, 32'h0000_0042, 32'd0);
    drive("r2_array", 1'b0, 32'h0, 32'h3000, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0,
          5'd2, 5'd7, 32'h0000_0042, 32'h0, 1'b0, 32'h0, 32'd1);

    w = 0;
    while (sb.size() != 0 && w < 10) begin
      @(posedge clk);
      w++;
    end
    #1;
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
